// File: rtl/aes_key_expansion_if.sv
// Request/stream bundle between the AES-128 key-schedule generator and its
// requester / round-key consumer (AddRoundKey stage).
interface aes_key_expansion_if;
    logic         start;
    logic [127:0] cipher_key;
    logic         reverse;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;

    modport master (
        output start, cipher_key, reverse, key_ready,
        input  round_key, round_idx, key_valid, busy, done
    );

    modport slave (
        input  start, cipher_key, reverse, key_ready,
        output round_key, round_idx, key_valid, busy, done
    );
endinterface

// File: rtl/aes_key_expansion.sv
// Sequential AES-128 key schedule: emits round keys 0..10 one per valid/ready handshake.
// Optional reverse order (10..0, with a forward precompute pass) under AES_KEYEXP_REVERSE_EN.
module aes_key_expansion #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                clk,
    input  logic                rst,
    aes_key_expansion_if.slave  kif
);
    // state   | meaning
    // IDLE    | waiting for start, no key presented
    // EMIT    | round_key/round_idx valid, advance on each handshake
    // PRECOMP | reverse only: run forward schedule to round 10, key_valid low
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1
`ifdef AES_KEYEXP_REVERSE_EN
        ,
        PRECOMP = 2'd2
`endif
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);
    localparam logic [3:0] PRE_LAST = 4'(NUM_ROUNDS - 1);

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       state;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sub_in, sub_out, t_word;
    logic [31:0]  n0, n1, n2, n3;
    logic [3:0]   rcon_idx;
    logic [127:0] fwd_key;

    assign {w3, w2, w1, w0} = round_key;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign sub_out[b*8 +: 8] = sbox(sub_in[b*8 +: 8]);
    end

    assign t_word  = sub_out ^ {24'h000000, rcon(rcon_idx)};
    assign n0      = w0 ^ t_word;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign fwd_key = {n3, n2, n1, n0};

`ifdef AES_KEYEXP_REVERSE_EN
    logic         rev_mode;
    logic         use_inv;
    logic [31:0]  p1, p2, p3;
    logic [127:0] inv_key;

    // The four S-boxes are shared: inverse step in reverse EMIT, forward otherwise.
    assign use_inv  = rev_mode && (state == EMIT);
    assign p3       = w3 ^ w2;
    assign p2       = w2 ^ w1;
    assign p1       = w1 ^ w0;
    assign sub_in   = use_inv ? rot_word(p3) : rot_word(w3);
    assign rcon_idx = use_inv ? round_idx : round_idx + 4'd1;
    assign inv_key  = {p3, p2, p1, w0 ^ t_word};
`else
    assign sub_in   = rot_word(w3);
    assign rcon_idx = round_idx + 4'd1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            round_key <= '0;
            round_idx <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
            rev_mode  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (kif.start) begin
                        round_key <= kif.cipher_key;
                        round_idx <= '0;
                        busy      <= 1'b1;
`ifdef AES_KEYEXP_REVERSE_EN
                        rev_mode  <= kif.reverse;
                        if (kif.reverse) begin
                            state     <= PRECOMP;
                            key_valid <= 1'b0;
                        end else begin
                            state     <= EMIT;
                            key_valid <= 1'b1;
                        end
`else
                        state     <= EMIT;
                        key_valid <= 1'b1;
`endif
                    end
                end
`ifdef AES_KEYEXP_REVERSE_EN
                PRECOMP: begin
                    round_key <= fwd_key;
                    round_idx <= round_idx + 4'd1;
                    if (round_idx == PRE_LAST) begin
                        state     <= EMIT;
                        key_valid <= 1'b1;
                    end
                end
`endif
                EMIT: begin
                    // key_valid is always high in EMIT, so key_ready alone marks a handshake
                    if (kif.key_ready) begin
`ifdef AES_KEYEXP_REVERSE_EN
                        if (rev_mode) begin
                            if (round_idx == 4'd0) begin
                                state     <= IDLE;
                                key_valid <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                round_key <= inv_key;
                                round_idx <= round_idx - 4'd1;
                            end
                        end else
`endif
                        if (round_idx == LAST_IDX) begin
                            state     <= IDLE;
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            round_key <= fwd_key;
                            round_idx <= round_idx + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign kif.round_key = round_key;
    assign kif.round_idx = round_idx;
    assign kif.key_valid = key_valid;
    assign kif.busy      = busy;
    assign kif.done      = done;
endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: known-answer table, random keys with
// random back-pressure against a FIPS-197 word-array model, and corner sequences.
module tb_aes_key_expansion;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    aes_key_expansion_if kif();
    aes_key_expansion #(.NUM_ROUNDS(10)) dut (.clk(clk), .rst(rst), .kif(kif));

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        int           round;
        logic [127:0] want;
    } vec_t;

    vec_t         vecs [5];
    logic [7:0]   sbox_m [256];
    logic [127:0] exp_keys [0:10];
    logic [127:0] fips_key;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Spec strings list byte 0 first; the bus carries byte 0 in the low bits.
    function automatic logic [127:0] bytes_le(input logic [127:0] s);
        logic [127:0] r;
        for (int n = 0; n < 16; n++) r[n*8 +: 8] = s[(15-n)*8 +: 8];
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box derived from GF(2^8) inversion plus the affine map.
    task automatic init_sbox();
        logic [7:0] inv, b, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            s = 8'h63 ^ b;
            for (int k = 1; k < 5; k++) begin
                b = {b[6:0], b[7]};
                s ^= b;
            end
            sbox_m[x] = s;
        end
    endtask

    task automatic compute_model(input logic [127:0] key);
        logic [7:0] w [0:43][0:3];
        logic [7:0] t [0:3];
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i/4][i%4] = key[i*8 +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                t = '{sbox_m[w[i-1][1]], sbox_m[w[i-1][2]], sbox_m[w[i-1][3]], sbox_m[w[i-1][0]]};
                t[0] ^= rc;
                rc = xtime(rc);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int r = 0; r <= 10; r++)
            for (int n = 0; n < 16; n++) exp_keys[r][n*8 +: 8] = w[4*r + n/4][n%4];
    endtask

    logic [127:0] got_keys [0:10];

    task automatic run_keys(input logic [127:0] key, input bit rev, input bit rnd_ready,
                            input int disturb_idx, input bit start_at_last);
        int hs, cyc, ndone, lat, exp_lat, exp_idx;
        bit eff_rev, held;
        logic [127:0] hk;
        logic [3:0]   hi;
        hs = 0; cyc = 0; ndone = 0; held = 1'b0; hk = '0; hi = '0;
`ifdef AES_KEYEXP_REVERSE_EN
        eff_rev = rev;
`else
        eff_rev = 1'b0;
`endif
        exp_lat = eff_rev ? 11 : 1;
        compute_model(key);
        @(negedge clk);
        kif.start = 1'b1; kif.cipher_key = key; kif.reverse = rev; kif.key_ready = 1'b1;
        @(negedge clk);
        kif.start = 1'b0; kif.reverse = 1'b0;
        lat = 1;
        while (!kif.key_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("start_latency", 128'(lat), 128'(exp_lat));
        check("busy_during", 128'(kif.busy), 128'(1));
        while (hs < 11 && cyc < 300) begin
            if (held) begin
                check("hold_key", kif.round_key, hk);
                check("hold_idx", 128'(kif.round_idx), 128'(hi));
            end
            kif.key_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            kif.start = 1'b0;
            if (disturb_idx >= 0 && kif.key_valid && int'(kif.round_idx) == disturb_idx) begin
                kif.start = 1'b1;
                kif.cipher_key = {$urandom, $urandom, $urandom, $urandom};
            end
            if (kif.key_valid && kif.key_ready) begin
                exp_idx = eff_rev ? 10 - hs : hs;
                check("round_idx", 128'(kif.round_idx), 128'(exp_idx));
                check("round_key", kif.round_key, exp_keys[exp_idx]);
                got_keys[exp_idx] = kif.round_key;
                if (start_at_last && hs == 10) begin
                    kif.start = 1'b1;
                    kif.cipher_key = {$urandom, $urandom, $urandom, $urandom};
                end
                hs++;
            end
            held = kif.key_valid && !kif.key_ready;
            hk = kif.round_key;
            hi = kif.round_idx;
            if (kif.done) ndone++;
            cyc++;
            @(negedge clk);
        end
        kif.start = 1'b0;
        kif.key_ready = 1'b0;
        check("valid_after_last", 128'(kif.key_valid), 128'(0));
        check("idle_after_last", 128'(kif.busy), 128'(0));
        for (int i = 0; i < 4; i++) begin
            if (kif.done) ndone++;
            @(negedge clk);
        end
        check("handshakes", 128'(hs), 128'(11));
        check("done_pulses", 128'(ndone), 128'(1));
        if (!rnd_ready) check("hs_cycles", 128'(cyc), 128'(11));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        kif.start = 1'b0; kif.cipher_key = '0; kif.reverse = 1'b0; kif.key_ready = 1'b0;
        init_sbox();
        fips_key = bytes_le(128'h2b7e151628aed2a6abf7158809cf4f3c);
        vecs[0] = '{fips_key, 0, fips_key};
        vecs[1] = '{fips_key, 1, bytes_le(128'ha0fafe1788542cb123a339392a6c7605)};
        vecs[2] = '{fips_key, 10, bytes_le(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)};
        vecs[3] = '{128'h0, 1, bytes_le(128'h62636363626363636263636362636363)};
        vecs[4] = '{128'h0, 10, bytes_le(128'hb4ef5bcb3e92e21123e951cf6f8f188e)};

        repeat (3) @(negedge clk);
        check("rst_round_key", kif.round_key, 128'h0);
        check("rst_round_idx", 128'(kif.round_idx), 128'(0));
        check("rst_key_valid", 128'(kif.key_valid), 128'(0));
        check("rst_busy", 128'(kif.busy), 128'(0));
        check("rst_done", 128'(kif.done), 128'(0));
        rst = 1'b0;

        // Ready with nothing valid must not move the block.
        kif.key_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready_valid", 128'(kif.key_valid), 128'(0));
        check("idle_ready_idx", 128'(kif.round_idx), 128'(0));
        check("idle_ready_busy", 128'(kif.busy), 128'(0));

        for (int v = 0; v < 5; v++) begin
            run_keys(vecs[v].key, 1'b0, 1'b0, -1, 1'b0);
            check($sformatf("kat%0d_round%0d", v, vecs[v].round), got_keys[vecs[v].round], vecs[v].want);
        end

        run_keys(fips_key, 1'b0, 1'b1, -1, 1'b0);
        run_keys(fips_key, 1'b0, 1'b0, 4, 1'b0);
        run_keys(fips_key, 1'b0, 1'b1, 4, 1'b0);
        run_keys({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, -1, 1'b1);

        // Reset partway through round 6.
        begin
            int guard;
            int nd;
            compute_model(fips_key);
            @(negedge clk);
            kif.start = 1'b1; kif.cipher_key = fips_key; kif.key_ready = 1'b1;
            @(negedge clk);
            kif.start = 1'b0;
            guard = 0;
            while (!(kif.key_valid && kif.round_idx == 4'd6) && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            check("reach_round6", 128'(kif.round_idx), 128'(6));
            #2 rst = 1'b1;
            #1;
            check("midrst_round_key", kif.round_key, 128'h0);
            check("midrst_round_idx", 128'(kif.round_idx), 128'(0));
            check("midrst_key_valid", 128'(kif.key_valid), 128'(0));
            check("midrst_busy", 128'(kif.busy), 128'(0));
            check("midrst_done", 128'(kif.done), 128'(0));
            @(negedge clk);
            rst = 1'b0;
            nd = 0;
            for (int i = 0; i < 4; i++) begin
                if (kif.done || kif.key_valid) nd++;
                @(negedge clk);
            end
            check("midrst_quiet", 128'(nd), 128'(0));
        end
        run_keys(fips_key, 1'b0, 1'b0, -1, 1'b0);

        for (int k = 0; k < 6; k++)
            run_keys({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, -1, 1'b0);

`ifdef AES_KEYEXP_REVERSE_EN
        run_keys(fips_key, 1'b1, 1'b0, -1, 1'b0);
        check("rev_first_key", got_keys[10], vecs[2].want);
        check("rev_last_key", got_keys[0], fips_key);
        run_keys({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, -1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
